// File: rtl/colour_detect.sv
// Purpose: per-frame colour detector; counts pixels whose target channel dominates and flags frames reaching THRESHOLD.
// Latency: colour_flag updates on the clock edge that samples eop (1 clock after the eop pixel).
// Backpressure: none; one pixel per clock from sop to eop inclusive, and pixels outside a frame are ignored.
module colour_detect #(
  parameter int unsigned THRESHOLD = 100,
  parameter int unsigned COLOUR    = 0,
  parameter int unsigned MARGIN    = 2,
  parameter int unsigned MIN_LEVEL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixel,
  input  logic        sop,
  input  logic        eop,
  output logic        colour_flag
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [19:0] CNT_MAX = '1;

  state_t      state;
  logic [19:0] cnt;
  logic [3:0]  tgt;
  logic [3:0]  oth1;
  logic [3:0]  oth2;
  logic        match;
  logic [19:0] cnt_base;
  logic [19:0] cnt_final;
  logic        accept;

  // Route the target channel and the two competing channels; unknown COLOUR values fall back to red.
  always_comb begin
    tgt  = pixel[11:8];
    oth1 = pixel[7:4];
    oth2 = pixel[3:0];
    case (COLOUR)
      1: begin
        tgt  = pixel[7:4];
        oth1 = pixel[11:8];
        oth2 = pixel[3:0];
      end
      2: begin
        tgt  = pixel[3:0];
        oth1 = pixel[11:8];
        oth2 = pixel[7:4];
      end
      default: begin
        tgt  = pixel[11:8];
        oth1 = pixel[7:4];
        oth2 = pixel[3:0];
      end
    endcase
  end

  // Match rule evaluated in 32-bit unsigned so channel + MARGIN can never wrap.
  always_comb begin
    match = (32'(tgt) >= MIN_LEVEL) &&
            (32'(tgt) >  32'(oth1) + MARGIN) &&
            (32'(tgt) >  32'(oth2) + MARGIN);
  end

  // Next count including the current pixel: a sop pixel starts from zero, and the count saturates.
  always_comb begin
    accept    = sop || (state == ACTIVE);
    cnt_base  = sop ? 20'd0 : cnt;
    cnt_final = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + {19'd0, match};
  end

  // Frame FSM with registered count and flag; the flag only moves on an accepted eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 20'd0;
      colour_flag <= 1'b0;
    end else if (accept) begin
      cnt <= cnt_final;
      if (eop) begin
        colour_flag <= (32'(cnt_final) >= THRESHOLD);
        state       <= IDLE;
      end else begin
        state <= ACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_colour_detect.sv
// Purpose: scoreboard bench for colour_detect with three parameterisations sharing one stimulus stream.
// Latency: expectations are pushed at each active edge and compared on the following falling edge.
// Backpressure: none; the driver issues one pixel per clock.
module tb_colour_detect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pixel;
  logic        sop;
  logic        eop;
  logic        flag_r;
  logic        flag_t0;
  logic        flag_g;

  always #5 clk = ~clk;

  colour_detect #(.THRESHOLD(100), .COLOUR(0), .MARGIN(2), .MIN_LEVEL(4)) dut_red (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .sop(sop), .eop(eop), .colour_flag(flag_r));

  colour_detect #(.THRESHOLD(0), .COLOUR(0), .MARGIN(2), .MIN_LEVEL(4)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .sop(sop), .eop(eop), .colour_flag(flag_t0));

  colour_detect #(.THRESHOLD(1), .COLOUR(1), .MARGIN(2), .MIN_LEVEL(4)) dut_grn (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .sop(sop), .eop(eop), .colour_flag(flag_g));

  typedef struct {
    bit    r;
    bit    t0;
    bit    g;
    string tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] frame_q[$];
  int          checks = 0;
  int          passed = 0;
  bit          hr, ht, hg;
  string       cur_tag;

  task automatic check1(input string name, input logic act, input bit exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Monitor: every cycle with a pending expectation compares all three flags.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check1({e.tag, "/red"}, flag_r, e.r);
      check1({e.tag, "/thr0"}, flag_t0, e.t0);
      check1({e.tag, "/green"}, flag_g, e.g);
    end
  end

  task automatic cyc(input logic [11:0] pix, input logic s, input logic e,
                     input bit er, input bit et, input bit eg);
    pixel = pix;
    sop   = s;
    eop   = e;
    @(posedge clk);
    sb_q.push_back('{r: er, t0: et, g: eg, tag: cur_tag});
    @(negedge clk);
  endtask

  task automatic add(input logic [11:0] pix, input int n);
    repeat (n) frame_q.push_back(pix);
  endtask

  // Send the queued pixels as one frame; close=0 leaves it open (no eop).
  task automatic send(input bit er, input bit eg, input bit close);
    int last;
    last = frame_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (close && i == last) begin
        hr = er;
        ht = 1'b1;
        hg = eg;
      end
      cyc(frame_q[i], (i == 0), (close && i == last), hr, ht, hg);
    end
    frame_q.delete();
  endtask

  task automatic stray(input logic [11:0] pix, input logic e);
    cyc(pix, 1'b0, e, hr, ht, hg);
  endtask

  initial begin
    rst_n = 1'b0;
    pixel = 12'h000;
    sop   = 1'b0;
    eop   = 1'b0;
    hr = 0; ht = 0; hg = 0;
    #1;
    check1("reset/red", flag_r, 1'b0);
    check1("reset/thr0", flag_t0, 1'b0);
    check1("reset/green", flag_g, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pixels and eop outside a frame are ignored, even with THRESHOLD 0.
    cur_tag = "idle_ignore";
    stray(12'hF00, 1'b0);
    stray(12'h0F0, 1'b0);
    stray(12'hF00, 1'b1);

    // Grey frames never set the flag.
    cur_tag = "dim1";
    add(12'h111, 101); send(0, 0, 1);
    cur_tag = "dim2";
    add(12'h111, 101); send(0, 0, 1);

    // Bright red frame sets the flag, held through the next frame until its eop.
    cur_tag = "bright";
    add(12'hF00, 101); send(1, 0, 1);
    cur_tag = "bright_hold";
    add(12'h111, 101); send(0, 0, 1);

    // Threshold boundary: 99 vs 100 matching pixels.
    cur_tag = "n99";
    add(12'hF00, 99); add(12'h000, 2); send(0, 0, 1);
    cur_tag = "n100";
    add(12'hF00, 100); add(12'h000, 1); send(1, 0, 1);

    // Match-rule edges: 0x622 and 0x633 match, 0x644 and 0x300 do not.
    cur_tag = "edge_633";
    add(12'h633, 100); send(1, 0, 1);
    cur_tag = "edge_644_300";
    add(12'h644, 100); add(12'h300, 50); send(0, 0, 1);
    cur_tag = "edge_mix100";
    add(12'h622, 50); add(12'h633, 50); add(12'h644, 1); add(12'h300, 1); send(1, 0, 1);
    cur_tag = "edge_mix99";
    add(12'h622, 50); add(12'h633, 49); add(12'h644, 10); add(12'h300, 10); send(0, 0, 1);

    // One-pixel frames on the green detector, then a stray eop that must not reopen a frame.
    cur_tag = "single_g1";
    add(12'h0F0, 1); send(0, 1, 1);
    cur_tag = "green_vs_blue_tie";
    add(12'h0FF, 5); send(0, 0, 1);
    cur_tag = "single_g2";
    add(12'h0F0, 1); send(0, 1, 1);
    cur_tag = "single_g0";
    add(12'h000, 1); send(0, 0, 1);
    cur_tag = "single_stray";
    stray(12'h0F0, 1'b1);
    stray(12'h0F0, 1'b0);

    // sop mid-frame restarts the count without updating the flag.
    cur_tag = "restart_pre";
    add(12'hF00, 101); send(1, 0, 1);
    cur_tag = "restart_part";
    add(12'hF00, 60); send(0, 0, 0);
    cur_tag = "restart_tail";
    add(12'hF00, 50); send(0, 0, 1);

    // Reset mid-frame clears the flag at once; a later eop without sop changes nothing.
    cur_tag = "rst_pre";
    add(12'hF00, 101); send(1, 0, 1);
    cur_tag = "rst_part";
    add(12'hF00, 30); send(0, 0, 0);
    #2;
    pixel = 12'hF00;
    rst_n = 1'b0;
    #1;
    check1("rst_async/red", flag_r, 1'b0);
    check1("rst_async/thr0", flag_t0, 1'b0);
    check1("rst_async/green", flag_g, 1'b0);
    hr = 0; ht = 0; hg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "rst_orphan";
    for (int i = 0; i < 20; i++) stray(12'hF00, (i == 19));
    cur_tag = "rst_recover";
    add(12'hF00, 101); send(1, 0, 1);

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
